led_breathe: RTL
================

Name: led_breathe

Overview:
- Downstream consumer of the tick divider's periodic strobe.
- Converts each `tick` pulse into one step of a triangular brightness ramp: up, hold, down, hold, repeat.
- Drives a single LED pin with a free-running PWM whose duty follows that ramp, producing a "breathing" LED.
- Sits between the 50 MHz clock-divider stage and the board LED pin.

Parameters:
- PWM_BITS, 8, width of PWM counter and duty; MAX = 2^PWM_BITS-1.
- STEP, 1, duty increment/decrement per tick; legal range 1..MAX.
- HOLD_TICKS, 4, ticks spent at each peak/trough; must be >= 1.

Ports:
- clk  input  1  system clock (50 MHz board oscillator).
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  level; 1 = run the breathe sequence, 0 = LED off and idle.
- tick  input  1  single-cycle strobe from the upstream divider; one ramp step per pulse.
- led  output  1  registered PWM output to the LED pin.
- duty  output  PWM_BITS  current duty value.
- phase  output  3  FSM state: IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4.
- cycle_done  output  1  one-clk pulse when a full breathe cycle completes.

Behaviour:
- Interface: one clock domain (`clk`); reset `rst` is asynchronous and active-high.
- Reset values: led=0, duty=0, phase=IDLE, cycle_done=0, pwm_cnt=0, hold_cnt=0.
- PWM counter:
  - pwm_cnt (PWM_BITS wide) increments every clk, wraps MAX->0, and runs regardless of state.
- LED output:
  - led <= (phase!=IDLE) && (pwm_cnt < duty), registered, so it lags by 1 clk.
  - duty=0 gives a permanently low LED.
  - duty=MAX gives led high for MAX of every 2^PWM_BITS clks.
- IDLE:
  - If enable=1, go to RAMP_UP on the next clk; no tick is required.
  - A tick arriving while in IDLE is ignored.
- RAMP_UP, on tick:
  - If duty+STEP >= MAX, set duty=MAX, hold_cnt=0, go to HOLD_HIGH.
  - Otherwise duty += STEP.
  - Compute the sum one bit wider; there is no wrap.
- HOLD_HIGH, on tick:
  - If hold_cnt==HOLD_TICKS-1, go to RAMP_DOWN and clear hold_cnt.
  - Otherwise hold_cnt++.
- RAMP_DOWN, on tick:
  - If duty <= STEP, set duty=0, hold_cnt=0, go to HOLD_LOW.
  - Otherwise duty -= STEP.
  - There is no underflow.
- HOLD_LOW, on tick:
  - If hold_cnt==HOLD_TICKS-1, go to RAMP_UP, clear hold_cnt, and pulse cycle_done=1 for exactly that clk.
  - Otherwise hold_cnt++.
- Without a tick, all states hold duty, hold_cnt and phase.
- Enable priority:
  - enable=0 in any state forces, on the next clk: phase=IDLE, duty=0, hold_cnt=0, cycle_done=0.
  - led=0 follows one clk after that via the output register.
  - enable=0 takes priority over a simultaneous tick.
- Re-enable: always restarts from duty=0 in RAMP_UP; no resume of a previous position.
- Tick on the same clk as the IDLE->RAMP_UP transition: ignored; the first step uses the next tick.
- Back-to-back ticks on consecutive clks: each is consumed as one step.
- rst asserted mid-ramp: all outputs take their reset values immediately (asynchronous). The sequence restarts only after rst deasserts and enable=1.
- cycle_done: never asserted for two consecutive clks; never asserted in IDLE.

Test Plan:
- Reset: drive enable=1 with ticks running, assert rst mid-RAMP_DOWN at duty=7 (PWM_BITS=4, STEP=4, HOLD_TICKS=2). Expect led=0, duty=0, phase=0 in the same cycle without waiting for a clk edge.
- Full cycle (PWM_BITS=4, STEP=4, HOLD_TICKS=2), enable=1, one tick every 20 clks:
  - Duty sequence 0,4,8,12,15 (saturated) with phase=2 after 4 ticks.
  - phase=3 after 2 more ticks.
  - Duty 11,7,3,0 with phase=4.
  - 2 more ticks give a cycle_done pulse of 1 clk with phase=1.
- PWM duty check at defaults: hold duty=64 (force by ticking 64 times) and count led highs over 256 consecutive clks. Expect exactly 64. At duty=255, expect 255.
- Enable drop: enable=0 on the same clk as a tick in RAMP_UP at duty=8. Expect next clk phase=0, duty=0 (not 12), led=0 one clk later. Re-enable: phase=1, duty stays 0 until the first tick.
- Saturation with an odd STEP (PWM_BITS=4, STEP=6): ramp up gives 6, 12, 15; ramp down gives 9, 3, 0. No wrap values appear.
- Back-to-back ticks on 5 consecutive clks from IDLE+enable (defaults): expect the first tick ignored if coincident with IDLE exit, then duty advances 1 per clk to 4.

Source files
------------

// File: rtl/led_breathe.sv
// Purpose: breathing-LED driver; each tick moves the PWM duty one step along an up/hold/down/hold triangle.
// Latency: phase/duty update on the clk after a tick; led is registered and lags phase/duty by one clk.
// Backpressure: none; tick is a fire-and-forget strobe, and ticks outside an active step state are dropped.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   enable     level; 1 runs the breathe sequence, 0 idles with the LED off
//   tick       one-clk strobe; one ramp/hold step per pulse
//   led        registered PWM output
//   duty       current duty value (PWM_BITS wide)
//   phase      FSM state: IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4
//   cycle_done one-clk pulse when HOLD_LOW wraps back into RAMP_UP
module led_breathe #(
  parameter int PWM_BITS   = 8,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                tick,
  output logic                led,
  output logic [PWM_BITS-1:0] duty,
  output logic [2:0]          phase,
  output logic                cycle_done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } phase_t;

  // HOLD_TICKS == 1 still needs a 1-bit counter so the compare is well formed.
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int SW = PWM_BITS + 1;

  localparam logic [PWM_BITS-1:0] MAX       = '1;
  localparam logic [SW-1:0]       MAX_W     = {1'b0, MAX};
  localparam logic [SW-1:0]       STEP_W    = SW'(STEP);
  localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0]       HOLD_ONE  = HW'(1);
  localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);

  phase_t              phase_q, phase_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic                done_d;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [SW-1:0]       up_sum;

  // One bit wider than duty so the saturation test cannot be fooled by a wrap.
  assign up_sum = {1'b0, duty_q} + STEP_W;

  always_comb begin
    phase_d = phase_q;
    duty_d  = duty_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (!enable) begin
      // Disable beats any tick in the same clk and always discards position.
      phase_d = IDLE;
      duty_d  = '0;
      hold_d  = '0;
    end else begin
      case (phase_q)
        IDLE: begin
          // Leaving IDLE does not consume a tick; the first step is the next tick.
          phase_d = RAMP_UP;
          duty_d  = '0;
          hold_d  = '0;
        end
        RAMP_UP: begin
          if (tick) begin
            if (up_sum >= MAX_W) begin
              duty_d  = MAX;
              hold_d  = '0;
              phase_d = HOLD_HIGH;
            end else begin
              duty_d = up_sum[PWM_BITS-1:0];
            end
          end
        end
        HOLD_HIGH: begin
          if (tick) begin
            if (hold_q == HOLD_LAST) begin
              hold_d  = '0;
              phase_d = RAMP_DOWN;
            end else begin
              hold_d = hold_q + HOLD_ONE;
            end
          end
        end
        RAMP_DOWN: begin
          if (tick) begin
            if ({1'b0, duty_q} <= STEP_W) begin
              duty_d  = '0;
              hold_d  = '0;
              phase_d = HOLD_LOW;
            end else begin
              duty_d = duty_q - STEP_W[PWM_BITS-1:0];
            end
          end
        end
        HOLD_LOW: begin
          if (tick) begin
            if (hold_q == HOLD_LAST) begin
              hold_d  = '0;
              phase_d = RAMP_UP;
              done_d  = 1'b1;
            end else begin
              hold_d = hold_q + HOLD_ONE;
            end
          end
        end
        default: begin
          phase_d = IDLE;
          duty_d  = '0;
          hold_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= IDLE;
      duty_q     <= '0;
      hold_q     <= '0;
      cycle_done <= 1'b0;
      pwm_cnt    <= '0;
      led        <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      duty_q     <= duty_d;
      hold_q     <= hold_d;
      cycle_done <= done_d;
      // Free-running; duty=MAX therefore leaves one low clk per period.
      pwm_cnt    <= pwm_cnt + PWM_ONE;
      led        <= (phase_q != IDLE) && (pwm_cnt < duty_q);
    end
  end

  assign duty  = duty_q;
  assign phase = phase_q;

endmodule
